// File: rtl/mod_vga_decoder.sv
// mod_vga_decoder
//   Recovers pixel coordinates and colour from an asynchronous analogue-style
//   VGA stream (1-bit r/g/b plus active-low hsync/vsync) sampled on the pixel
//   clock. Line/frame timing is tracked, verified against the nominal totals,
//   and only once LOCK_FRAMES consecutive good frames are seen are active
//   pixels presented. All outputs are registered; pin-to-output latency is 3.
//
// Ports
//   in_clk_25_175_mhz            pixel clock (only clock)
//   in_reset_n                   asynchronous active-low reset
//   in_vga_r/g/b                 asynchronous pixel colour
//   in_vga_hsync/vsync           asynchronous active-low sync
//   out_pix_x/y   [9:0]          active coordinate (held while not valid)
//   out_pix_r/g/b                captured colour (0 while not valid)
//   out_pix_valid                active pixel on outputs
//   out_frame_start              pulse with pixel (0,0)
//   out_locked                   timing lock status
//   out_error                    one-cycle pulse on loss of lock/tracking
//
// Handshake: there is no back-pressure. out_pix_valid qualifies the pixel
// fields for exactly the cycle it is high; the consumer must take it then.
module mod_vga_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       in_clk_25_175_mhz,
  input  logic       in_reset_n,
  input  logic       in_vga_r,
  input  logic       in_vga_g,
  input  logic       in_vga_b,
  input  logic       in_vga_hsync,
  input  logic       in_vga_vsync,
  output logic [9:0] out_pix_x,
  output logic [9:0] out_pix_y,
  output logic       out_pix_r,
  output logic       out_pix_g,
  output logic       out_pix_b,
  output logic       out_pix_valid,
  output logic       out_frame_start,
  output logic       out_locked,
  output logic       out_error
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [9:0]  COORD_MAX = 10'h3FF;
  localparam logic [10:0] NH_MAX    = 11'h7FF;
  // Synchroniser bit order {hsync, vsync, r, g, b}; sync paths idle high.
  localparam logic [4:0]  SYNC_RST  = 5'b11000;

  // Both synchroniser stages carry all five inputs together so the colour
  // stays aligned with the sync edges that position it.
  logic [4:0]  meta_q, meta_d;
  logic [4:0]  sync_q, sync_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [10:0] nh_q, nh_d;      // hsync falls since the last vsync fall
  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        seen_q, seen_d;  // an hsync fall has occurred while searching

  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic        pix_r_q, pix_r_d;
  logic        pix_g_q, pix_g_d;
  logic        pix_b_q, pix_b_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;

  logic        hs_s, vs_s, r_s, g_s, b_s;
  logic        h_fall, v_fall;
  logic [10:0] nh_inc;
  logic        line_bad, frame_bad, h_sat, fail;
  logic        in_h, in_v, active;
  logic [9:0]  x_new, y_new;

  always_comb begin
    meta_d = {in_vga_hsync, in_vga_vsync, in_vga_r, in_vga_g, in_vga_b};
    sync_d = meta_q;
    {hs_s, vs_s, r_s, g_s, b_s} = sync_q;

    h_fall    = hs_prev_q & ~hs_s;
    v_fall    = vs_prev_q & ~vs_s;
    hs_prev_d = hs_s;
    vs_prev_d = vs_s;

    // Position of the current synchronised sample.
    if (h_fall)                h_d = 10'd0;
    else if (h_q == COORD_MAX) h_d = COORD_MAX;
    else                       h_d = h_q + 10'd1;

    if (v_fall)                v_d = 10'd0;
    else if (h_fall && (v_q != COORD_MAX)) v_d = v_q + 10'd1;
    else                       v_d = v_q;

    // A coincident hsync fall belongs to the frame that this vsync fall ends.
    if (h_fall && (nh_q != NH_MAX)) nh_inc = nh_q + 11'd1;
    else                            nh_inc = nh_q;
    nh_d = v_fall ? 11'd0 : nh_inc;

    line_bad  = h_fall && ((int'(h_q) + 1) != H_TOTAL);
    frame_bad = v_fall && (int'(nh_inc) != V_TOTAL);
    h_sat     = (h_d == COORD_MAX);
    fail      = (state_q != ST_SEARCH) && (line_bad || frame_bad || h_sat);

    state_d = state_q;
    good_d  = good_q;
    seen_d  = seen_q;
    error_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (v_fall && (seen_q || h_fall)) begin
          state_d = ST_TRACK;
          good_d  = 8'd0;
          seen_d  = 1'b0;
        end else if (h_fall) begin
          seen_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (fail) begin
          state_d = ST_SEARCH;
          seen_d  = 1'b0;
          error_d = 1'b1;
        end else if (v_fall) begin
          good_d = good_q + 8'd1;
          if ((int'(good_q) + 1) >= LOCK_FRAMES) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (fail) begin
          state_d = ST_SEARCH;
          seen_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    // Activity follows the next state so that a lock loss drops valid in the
    // same output cycle that out_error pulses.
    in_h   = (int'(h_d) >= H_START) && (int'(h_d) < H_START + H_ACTIVE);
    in_v   = (int'(v_d) >= V_START) && (int'(v_d) < V_START + V_ACTIVE);
    active = (state_d == ST_LOCKED) && in_h && in_v;
    x_new  = h_d - 10'(H_START);
    y_new  = v_d - 10'(V_START);

    pix_x_d       = active ? x_new : pix_x_q;
    pix_y_d       = active ? y_new : pix_y_q;
    pix_r_d       = active & r_s;
    pix_g_d       = active & g_s;
    pix_b_d       = active & b_s;
    pix_valid_d   = active;
    frame_start_d = active && (x_new == 10'd0) && (y_new == 10'd0);
    locked_d      = (state_d == ST_LOCKED);
  end

  always_ff @(posedge in_clk_25_175_mhz or negedge in_reset_n) begin
    if (!in_reset_n) begin
      meta_q        <= SYNC_RST;
      sync_q        <= SYNC_RST;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      nh_q          <= 11'd0;
      state_q       <= ST_SEARCH;
      good_q        <= 8'd0;
      seen_q        <= 1'b0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      pix_r_q       <= 1'b0;
      pix_g_q       <= 1'b0;
      pix_b_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      meta_q        <= meta_d;
      sync_q        <= sync_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_q           <= h_d;
      v_q           <= v_d;
      nh_q          <= nh_d;
      state_q       <= state_d;
      good_q        <= good_d;
      seen_q        <= seen_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
    end
  end

  assign out_pix_x       = pix_x_q;
  assign out_pix_y       = pix_y_q;
  assign out_pix_r       = pix_r_q;
  assign out_pix_g       = pix_g_q;
  assign out_pix_b       = pix_b_q;
  assign out_pix_valid   = pix_valid_q;
  assign out_frame_start = frame_start_q;
  assign out_locked      = locked_q;
  assign out_error       = error_q;

endmodule

// File: tb/tb_mod_vga_decoder.sv
// Bench for mod_vga_decoder using a reduced 40x20 timing so whole frames fit
// comfortably in simulation.
module tb_mod_vga_decoder;

  localparam int HT   = 40;
  localparam int VT   = 20;
  localparam int HS   = 8;
  localparam int VS   = 3;
  localparam int HA   = 24;
  localparam int VA   = 12;
  localparam int LF   = 2;
  localparam int HSW  = 4;
  localparam int VSW  = 2;
  localparam int NPIX = HA * VA;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       r, g, b, hs, vs;
  logic [9:0] px, py;
  logic       pr, pg, pb, pv, fs, lk, er;

  mod_vga_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .in_clk_25_175_mhz(clk),
    .in_reset_n(rst_n),
    .in_vga_r(r),
    .in_vga_g(g),
    .in_vga_b(b),
    .in_vga_hsync(hs),
    .in_vga_vsync(vs),
    .out_pix_x(px),
    .out_pix_y(py),
    .out_pix_r(pr),
    .out_pix_g(pg),
    .out_pix_b(pb),
    .out_pix_valid(pv),
    .out_frame_start(fs),
    .out_locked(lk),
    .out_error(er)
  );

  // scoreboard
  logic [26:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int check_cyc = -1;
  int red_done = 0;
  int win_err, win_valid;

  // reference model: works on the synchronised sample stream with plain ints
  int m_phs, m_pvs, m_h, m_v, m_st, m_good, m_seen, m_nh, m_x, m_y;

  function automatic void model_reset();
    m_phs = 1; m_pvs = 1; m_h = 0; m_v = 0; m_st = 0;
    m_good = 0; m_seen = 0; m_nh = 0; m_x = 0; m_y = 0;
  endfunction

  function automatic logic [26:0] model_step(input logic hi, input logic vi,
                                             input logic ri, input logic gi,
                                             input logic bi);
    bit hf, vf, fail, err, act;
    int old_h;
    logic [9:0] ox, oy;
    hf = (m_phs == 1) && (hi == 1'b0);
    vf = (m_pvs == 1) && (vi == 1'b0);
    m_phs = int'(hi);
    m_pvs = int'(vi);
    old_h = m_h;
    m_h = hf ? 0 : ((old_h + 1 > 1023) ? 1023 : old_h + 1);
    if (vf) m_v = 0;
    else if (hf) m_v = (m_v + 1 > 1023) ? 1023 : m_v + 1;
    if (hf) m_nh++;
    fail = 0;
    if (m_st != 0) begin
      if (hf && (old_h + 1 != HT)) fail = 1;
      if (vf && (m_nh != VT)) fail = 1;
      if (m_h == 1023) fail = 1;
    end
    err = 0;
    if (m_st == 0) begin
      if (hf) m_seen = 1;
      if (vf && m_seen == 1) begin m_st = 1; m_good = 0; end
    end else if (fail) begin
      m_st = 0; m_seen = 0; err = 1;
    end else if (vf && m_st == 1) begin
      m_good++;
      if (m_good >= LF) m_st = 2;
    end
    if (vf) m_nh = 0;
    act = (m_st == 2) && (m_h >= HS) && (m_h < HS + HA) &&
          (m_v >= VS) && (m_v < VS + VA);
    if (act) begin m_x = m_h - HS; m_y = m_v - VS; end
    ox = m_x[9:0];
    oy = m_y[9:0];
    return {act, ox, oy, act & ri, act & gi, act & bi,
            act && (m_x == 0) && (m_y == 0), m_st == 2, err};
  endfunction

  function automatic logic [26:0] obs();
    return {pv, px, py, pr, pg, pb, fs, lk, er};
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // driver tasks
  task automatic drive_cycle(input logic hi, input logic vi, input logic ri,
                             input logic gi, input logic bi);
    logic [26:0] e, o;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL model cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    if (er === 1'b1) win_err++;
    if (pv === 1'b1) win_valid++;
    if (cyc == check_cyc) begin
      total++;
      red_done = 1;
      if (!(pv === 1'b1 && px === 10'd0 && py === 10'd0 && pr === 1'b1 && fs === 1'b1)) begin
        bad++;
        $display("FAIL red_pixel got v=%b x=%0d y=%0d r=%b fs=%b want v=1 x=0 y=0 r=1 fs=1",
                 pv, px, py, pr, fs);
      end
    end
    hs = hi; vs = vi; r = ri; g = gi; b = bi;
    exp_q.push_back(model_step(hi, vi, ri, gi, bi));
  endtask

  task automatic drive_frame(input int lines, input int short_idx, input int short_len,
                             input bit red_only, input int stop_after);
    int n, len;
    logic cr, cg, cb;
    n = 0;
    for (int l = 0; l < lines; l++) begin
      len = (l == short_idx) ? short_len : HT;
      for (int c = 0; c < len; c++) begin
        if (stop_after >= 0 && n == stop_after) return;
        if (red_only) begin
          cr = (l == VS && c == HS); cg = 1'b0; cb = 1'b0;
        end else begin
          cr = 1'($urandom_range(0, 1));
          cg = 1'($urandom_range(0, 1));
          cb = 1'($urandom_range(0, 1));
        end
        drive_cycle(c >= HSW, l >= VSW, cr, cg, cb);
        if (red_only && l == VS && c == HS) check_cyc = cyc + 3;
        n++;
      end
    end
  endtask

  task automatic hold_reset_check(input string name);
    repeat (3) @(negedge clk);
    check(name, int'(obs()), 0);
  endtask

  // Called at a negedge with pins idle; the two reset-valued synchroniser
  // samples come out before the first real pin sample.
  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(model_step(hs, vs, r, g, b));
  endtask

  typedef struct {
    int lines;
    int short_idx;
    int short_len;
    int exp_err;
    int exp_lock;
    int exp_valid;
  } vec_t;

  vec_t tab[16];

  initial begin
    tab[0]  = '{VT,   -1, 0,      0, 0, 0};
    tab[1]  = '{VT,   -1, 0,      0, 0, 0};
    tab[2]  = '{VT,   -1, 0,      0, 1, NPIX};
    tab[3]  = '{VT,   -1, 0,      0, 1, NPIX};
    tab[4]  = '{VT,    5, HT - 1, 1, 0, 3 * HA};
    tab[5]  = '{VT,   -1, 0,      0, 0, 0};
    tab[6]  = '{VT,   -1, 0,      0, 0, 0};
    tab[7]  = '{VT,   -1, 0,      0, 1, NPIX};
    tab[8]  = '{VT-1, -1, 0,      0, 1, NPIX};
    tab[9]  = '{VT,   -1, 0,      1, 0, 0};
    tab[10] = '{VT,   -1, 0,      0, 0, 0};
    tab[11] = '{VT-1, -1, 0,      0, 0, 0};
    tab[12] = '{VT,   -1, 0,      1, 0, 0};
    tab[13] = '{VT,   -1, 0,      0, 0, 0};
    tab[14] = '{VT,   -1, 0,      0, 0, 0};
    tab[15] = '{VT,   -1, 0,      0, 1, NPIX};

    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; r = 1'b0; g = 1'b0; b = 1'b0;
    hold_reset_check("reset_outputs");
    release_reset();

    for (int i = 0; i < 16; i++) begin
      win_err = 0;
      win_valid = 0;
      drive_frame(tab[i].lines, tab[i].short_idx, tab[i].short_len, 1'b0, -1);
      check($sformatf("vec%0d_errors", i), win_err, tab[i].exp_err);
      check($sformatf("vec%0d_locked", i), int'(lk), tab[i].exp_lock);
      check($sformatf("vec%0d_valid_count", i), win_valid, tab[i].exp_valid);
    end

    // single red pixel at the first active position while locked
    drive_frame(VT, -1, 0, 1'b1, -1);
    check("red_pixel_reached", red_done, 1);

    // hsync stuck high until h saturates
    win_err = 0;
    repeat (1100) drive_cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check("saturate_errors", win_err, 1);
    check("saturate_locked", int'(lk), 0);

    // relock, then reset asynchronously in the middle of an active line
    win_err = 0;
    repeat (3) drive_frame(VT, -1, 0, 1'b0, -1);
    check("relock_locked", int'(lk), 1);
    check("relock_errors", win_err, 0);
    drive_frame(VT, -1, 0, 1'b0, 5 * HT + 20);
    check("pre_reset_valid", int'(pv), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(obs()), 0);
    hs = 1'b1; vs = 1'b1; r = 1'b0; g = 1'b0; b = 1'b0;
    exp_q.delete();
    hold_reset_check("held_reset_outputs");
    release_reset();
    win_err = 0;
    repeat (2) drive_frame(VT, -1, 0, 1'b0, -1);
    check("post_reset_not_locked", int'(lk), 0);
    drive_frame(VT, -1, 0, 1'b0, -1);
    check("post_reset_locked", int'(lk), 1);
    check("post_reset_errors", win_err, 0);
    repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
